// File: rtl/snake_pkg.sv
// Shared snake-game definitions: game states, scan codes, field bounds
// and the apple generator FSM encoding.
package snake_pkg;

  localparam logic [1:0] PLAY = 2'b10;
  localparam logic [1:0] IDLE = 2'b00;

  localparam logic [1:0] SCAN_NONE = 2'd0;
  localparam logic [1:0] SCAN_HEAD = 2'd1;
  localparam logic [1:0] SCAN_BODY = 2'd2;
  localparam logic [1:0] SCAN_WALL = 2'd3;

  localparam logic [5:0] X_MIN = 6'd1;
  localparam logic [5:0] X_MAX = 6'd38;
  localparam logic [5:0] Y_MIN = 6'd1;
  localparam logic [5:0] Y_MAX = 6'd28;

  localparam logic [5:0] FALL_X = 6'd20;
  localparam logic [5:0] FALL_Y = 6'd15;

  localparam int CELL_SHIFT = 4;

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    EAT  = 2'd1,
    SEEK = 2'd2
  } apple_state_t;

  function automatic logic in_field(input logic [5:0] x, input logic [5:0] y);
    return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with a nonzero seed; shifts right every
// cycle, XORing the tap mask in whenever a one falls out of bit 0.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= SEED;
    else
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  end

  assign value = lfsr;

endmodule

// File: rtl/apple_gen.sv
// Apple placement for the snake game: detects the head eating the apple,
// pulses add_cube, then relocates the apple to a random free field cell.
module apple_gen
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [5:0]  APPLE_X0  = 6'd24,
  parameter logic [5:0]  APPLE_Y0  = 6'd10,
  parameter int          SEEK_MAX  = 63
) (
  input  logic       CLK_50M,
  input  logic       RSTn,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [1:0] game_status,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic       add_cube,
  output logic [5:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple
);

  logic [15:0]  rnd;
  logic [5:0]   cand_x;
  logic [5:0]   cand_y;
  logic         cand_ok;
  logic         unused_rnd;

  apple_state_t state, state_next;
  logic [5:0]   rej_cnt, rej_next;
  logic [5:0]   apple_x_next, apple_y_next;

  lfsr16 #(
    .SEED (LFSR_SEED),
    .TAPS (16'hB400)
  ) u_lfsr (
    .clk   (CLK_50M),
    .rst_n (RSTn),
    .value (rnd)
  );

  assign cand_x     = rnd[5:0];
  assign cand_y     = {1'b0, rnd[12:8]};
  assign unused_rnd = ^{rnd[15:13], rnd[7:6]};
  assign cand_ok    = in_field(cand_x, cand_y) && !((cand_x == head_x) && (cand_y == head_y));

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      state   <= LIVE;
      rej_cnt <= 6'd0;
      apple_x <= APPLE_X0;
      apple_y <= APPLE_Y0;
    end else begin
      state   <= state_next;
      rej_cnt <= rej_next;
      apple_x <= apple_x_next;
      apple_y <= apple_y_next;
    end
  end

  always_comb begin
    state_next   = state;
    rej_next     = rej_cnt;
    apple_x_next = apple_x;
    apple_y_next = apple_y;
    case (state)
      LIVE: begin
        if ((game_status == PLAY) && (head_x == apple_x) && (head_y == apple_y))
          state_next = EAT;
      end
      EAT: begin
        rej_next   = 6'd0;
        state_next = SEEK;
      end
      SEEK: begin
        // Once the reject budget is spent, place deterministically instead.
        if (rej_cnt == 6'(SEEK_MAX)) begin
          apple_x_next = FALL_X;
          apple_y_next = ((head_x == FALL_X) && (head_y == FALL_Y)) ? FALL_Y + 6'd1 : FALL_Y;
          state_next   = LIVE;
        end else if (cand_ok) begin
          apple_x_next = cand_x;
          apple_y_next = cand_y;
          state_next   = LIVE;
        end else begin
          rej_next = rej_cnt + 6'd1;
        end
      end
      default: state_next = LIVE;
    endcase
  end

  assign add_cube = (state == EAT);

  assign apple = (x_pos < 10'd640) && (y_pos < 10'd480) &&
                 (x_pos[9:CELL_SHIFT] == apple_x) && (y_pos[9:CELL_SHIFT] == apple_y);

endmodule

// File: tb/tb_apple_gen.sv
// Self-checking bench for apple_gen: a cycle-level reference model predicts
// each relocation by walking the LFSR sequence forward from the eat event.
module tb_apple_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] hx, hy;
  logic [1:0] gs;
  logic [9:0] xp, yp;
  logic       add_cube;
  logic [5:0] ax, ay;
  logic       apple;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int p0;
  int cyc = 0;
  bit forced = 1'b0;
  bit seen;

  always #10 clk = ~clk;

  apple_gen dut (
    .CLK_50M     (clk),
    .RSTn        (rst_n),
    .head_x      (hx),
    .head_y      (hy),
    .game_status (gs),
    .x_pos       (xp),
    .y_pos       (yp),
    .add_cube    (add_cube),
    .apple_x     (ax),
    .apple_y     (ay),
    .apple       (apple)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Returns {rejects, x, y}; l is the LFSR value held just before the eat edge.
  function automatic logic [19:0] predict(input logic [15:0] l, input logic [5:0] px,
                                          input logic [5:0] py, input bit f);
    logic [15:0] v;
    logic [5:0]  cx, cy;
    v = step(step(l));
    for (int k = 0; k < 63; k++) begin
      cx = f ? 6'd0 : v[5:0];
      cy = f ? 6'd0 : {1'b0, v[12:8]};
      if (cx >= 1 && cx <= 38 && cy >= 1 && cy <= 28 && !(cx == px && cy == py))
        return {8'(k), cx, cy};
      v = step(v);
    end
    return {8'd63, 6'd20, (px == 6'd20 && py == 6'd15) ? 6'd16 : 6'd15};
  endfunction

  logic [15:0] m_lfsr;
  logic [5:0]  m_ax, m_ay;
  logic        m_add;
  bit          m_busy;
  logic [19:0] m_pred;
  int          m_eat_at;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_ax   <= 6'd24;
      m_ay   <= 6'd10;
      m_add  <= 1'b0;
      m_busy <= 1'b0;
    end else begin
      m_lfsr <= step(m_lfsr);
      m_add  <= 1'b0;
      if (!m_busy && gs == 2'b10 && hx == m_ax && hy == m_ay) begin
        m_add    <= 1'b1;
        m_busy   <= 1'b1;
        m_pred   <= predict(m_lfsr, hx, hy, forced);
        m_eat_at <= cyc;
      end else if (m_busy && cyc == m_eat_at + 2 + int'(m_pred[19:12])) begin
        m_ax   <= m_pred[11:6];
        m_ay   <= m_pred[5:0];
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("add_cube", add_cube, m_add);
    chk("apple_x", ax, m_ax);
    chk("apple_y", ay, m_ay);
    chk("apple_scan", apple,
        (xp < 640 && yp < 480 && xp[9:4] == m_ax && yp[9:4] == m_ay));
    if (add_cube === 1'b1) pulses++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    hx = 6'd10; hy = 6'd5; gs = 2'b10; xp = 10'd0; yp = 10'd0;
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    p0 = pulses;
    cycles(1000);
    chk("idle_pulses", 16'(pulses - p0), 16'd0);
    chk("reset_ax", ax, 16'd24);
    chk("reset_ay", ay, 16'd10);

    hx = 6'd24; hy = 6'd10; p0 = pulses;
    cycles(100);
    chk("eat_pulses", 16'(pulses - p0), 16'd1);
    chk("new_in_field", 16'(ax >= 1 && ax <= 38 && ay >= 1 && ay <= 28), 16'd1);
    chk("new_not_old", 16'(ax == 24 && ay == 10), 16'd0);

    gs = 2'b00; hx = m_ax; hy = m_ay; p0 = pulses;
    cycles(50);
    chk("nonplay_pulses", 16'(pulses - p0), 16'd0);
    chk("nonplay_ax", ax, 16'(hx));
    chk("nonplay_ay", ay, 16'(hy));
    gs = 2'b10;
    cycles(100);
    chk("play_pulses", 16'(pulses - p0), 16'd1);

    forced = 1'b1;
    force dut.rnd = 16'h0000;
    hx = m_ax; hy = m_ay; p0 = pulses;
    cycles(80);
    chk("forced_pulses", 16'(pulses - p0), 16'd1);
    chk("fallback_x", ax, 16'd20);
    chk("fallback_y", ay, 16'd15);
    hx = 6'd20; hy = 6'd15;
    cycles(80);
    chk("fallback2_x", ax, 16'd20);
    chk("fallback2_y", ay, 16'd16);
    release dut.rnd;
    forced = 1'b0;

    hx = 6'd10; hy = 6'd5;
    cycles(5);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    hx = 6'd24; hy = 6'd10;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (add_cube === 1'b1) seen = 1'b1;
    end
    chk("reseek_pulse_seen", 16'(seen), 16'd1);
    @(posedge clk);
    #2;
    hx = 6'd10; hy = 6'd5;
    rst_n = 1'b0;
    #1;
    chk("async_add_cube", add_cube, 16'd0);
    chk("async_ax", ax, 16'd24);
    chk("async_ay", ay, 16'd10);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    hx = 6'd24; hy = 6'd10; p0 = pulses;
    cycles(100);
    chk("restart_pulses", 16'(pulses - p0), 16'd1);

    rst_n = 1'b0;
    hx = 6'd10; hy = 6'd5;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    for (int x = 384; x < 400; x++) begin
      xp = 10'(x); yp = 10'(160 + x - 384);
      #1;
      chk("scan_in", apple, 16'd1);
    end
    xp = 10'd400; yp = 10'd165; #1; chk("scan_x400", apple, 16'd0);
    xp = 10'd390; yp = 10'd176; #1; chk("scan_y176", apple, 16'd0);
    xp = 10'd700; yp = 10'd165; #1; chk("scan_x700", apple, 16'd0);
    xp = 10'd0; yp = 10'd0;
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
